updown_mod_counter: RTL



---
 rtl/counter_pkg.sv | 14 +
 rtl/updown_mod_next.sv | 49 ++++
 rtl/updown_mod_counter.sv | 96 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared mode encodings and FSM state type for the up/down modulus counter.
package counter_pkg;

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count: wraps in FREE, clamps at the ends otherwise, holds in reserved mode.
module updown_mod_next
    import counter_pkg::*;
#(
    parameter int N   = 8,
    parameter int MAX = 2**N-1
) (
    input  logic [N-1:0] Q,
    input  logic         up_down_n,
    input  logic [1:0]   mode,
    output logic [N-1:0] next_q,
    output logic         will_wrap
);

    localparam logic [N-1:0] MAX_Q = N'(MAX);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (Q == MAX_Q);
    assign w_at_zero = (Q == '0);

    always_comb begin
        next_q    = Q;
        will_wrap = 1'b0;
        case (mode)
            MODE_FREE: begin
                if (up_down_n) begin
                    next_q    = w_at_max ? '0 : Q + 1'b1;
                    will_wrap = w_at_max;
                end else begin
                    next_q    = w_at_zero ? MAX_Q : Q - 1'b1;
                    will_wrap = w_at_zero;
                end
            end
            MODE_SAT, MODE_ONESHOT: begin
                if (up_down_n)
                    next_q = w_at_max ? Q : Q + 1'b1;
                else
                    next_q = w_at_zero ? Q : Q - 1'b1;
            end
            default: begin
                next_q    = Q;
                will_wrap = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with clamped parallel load, programmable modulus and FREE/SAT/ONESHOT modes.
// state   | meaning
// ST_RUN  | counting allowed (all modes)
// ST_HALT | one-shot finished; only load or reset (or leaving ONESHOT) resumes
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int N   = 8,
    parameter int MAX = 2**N-1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         up_down_n,
    input  logic [1:0]   mode,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         wrap,
    output logic         done
);

    localparam logic [N-1:0] MAX_Q = N'(MAX);

    logic [N-1:0] r_q;
    logic         r_wrap;
    logic         r_done;
    state_t       r_state;

    logic [N-1:0] w_next_q;
    logic         w_will_wrap;
    logic [N-1:0] w_load_val;

    updown_mod_next #(
        .N   (N),
        .MAX (MAX)
    ) u_next (
        .Q         (r_q),
        .up_down_n (up_down_n),
        .mode      (mode),
        .next_q    (w_next_q),
        .will_wrap (w_will_wrap)
    );

    assign w_load_val = (D > MAX_Q) ? MAX_Q : D;
    assign tc         = up_down_n ? (r_q == MAX_Q) : (r_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (load) begin
            r_q     <= w_load_val;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (mode != MODE_ONESHOT) begin
            // Any non-oneshot mode releases a halted one-shot on this edge.
            r_state <= ST_RUN;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            if (en && (mode == MODE_FREE)) begin
                r_q    <= w_next_q;
                r_wrap <= w_will_wrap;
            end else if (en && (mode == MODE_SAT)) begin
                r_q <= w_next_q;
            end
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (en) begin
                        if (tc) begin
                            r_state <= ST_HALT;
                            r_done  <= 1'b1;
                        end else begin
                            r_q <= w_next_q;
                        end
                    end
                end
                ST_HALT: begin
                    r_done <= 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign Q    = r_q;
    assign wrap = r_wrap;
    assign done = r_done;

endmodule
